// File: rtl/bus_width_increase.sv
// rtl/bus_width_increase.sv - packs a narrow valid/ready stream into a wide registered word, little-endian lanes
// Optional early word close via input_last/output_last when BUS_WIDTH_INCREASE_FLUSH_EN is defined.
module bus_width_increase #(
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic [SIZE_IN-1:0]  data_in,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [SIZE_OUT-1:0] data_out
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
  ,
  input  logic                input_last,
  output logic                output_last
`endif
);

  localparam int RATIO = SIZE_OUT / SIZE_IN;
  localparam int CW    = $clog2(RATIO);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SIZE_OUT-1:0] acc_q, acc_d;
  logic [SIZE_OUT-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [SIZE_OUT-1:0] word;
  logic                last_in;
  logic                closing;
  logic                in_fire;
  logic                out_fire;

`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
  logic last_q, last_d;
  assign last_in     = input_last;
  assign output_last = last_q;
`else
  assign last_in = 1'b0;
`endif

  assign closing      = (cnt_q == CW'(RATIO - 1)) | last_in;
  // Only a closing beat can stall, and only while the held word is not leaving.
  assign input_ready  = ~closing | ~valid_q | output_ready;
  assign in_fire      = input_valid & input_ready;
  assign out_fire     = valid_q & output_ready;
  assign output_valid = valid_q;
  assign data_out     = data_q;

  // Lanes below cnt come from the accumulator, lane cnt is the closing beat, lanes above are zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(cnt_q)) begin
        word[k*SIZE_IN +: SIZE_IN] = acc_q[k*SIZE_IN +: SIZE_IN];
      end else if (k == int'(cnt_q)) begin
        word[k*SIZE_IN +: SIZE_IN] = data_in;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    last_d  = last_q;
`endif
    if (out_fire) begin
      valid_d = 1'b0;
    end
    if (in_fire) begin
      if (closing) begin
        data_d  = word;
        valid_d = 1'b1;
        cnt_d   = '0;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
        last_d  = last_in;
`endif
      end else begin
        acc_d[cnt_q*SIZE_IN +: SIZE_IN] = data_in;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
      last_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_width_increase.sv
// tb/tb_bus_width_increase.sv - randomized self-checking bench for bus_width_increase against a byte-queue packing model
module tb_bus_width_increase;

  logic        clk;
  logic        reset_n;
  logic        input_valid;
  logic        input_ready;
  logic [7:0]  data_in;
  logic        output_valid;
  logic        output_ready;
  logic [31:0] data_out;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
  logic        input_last;
  logic        output_last;
`endif

  int errors = 0;
  int checks = 0;
  int timeouts = 0;
  int cyc = 0;

  logic [7:0]  bq[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_t[$];

  bus_width_increase #(.SIZE_IN(8), .SIZE_OUT(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .data_in      (data_in),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .data_out     (data_out)
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    ,
    .input_last   (input_last),
    .output_last  (output_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: accepted bytes gather in a queue; four bytes (or a last beat) form one word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (input_valid && input_ready) begin
        logic        close;
        logic [31:0] w;
        bq.push_back(data_in);
        close = (bq.size() == 4);
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
        close = close | input_last;
`endif
        if (close) begin
          w = 32'h0;
          for (int k = 0; k < bq.size(); k++) w[k*8 +: 8] = bq[k];
          exp_q.push_back(w);
          bq.delete();
        end
      end
      if (output_valid && output_ready) begin
        got_q.push_back(data_out);
        got_t.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    bq.delete();
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    input_valid = 1'b1;
    data_in = b;
    #1;
    n = 0;
    while (input_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeouts++;
    tick();
    input_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    input_valid = 1'b0;
    output_ready = 1'b0;
    data_in = 8'h00;
    repeat (3) tick();
    checks++;
    if (output_valid !== 1'b0 || data_out !== 32'h0)
      begin errors++; $display("FAIL reset_state: valid=%b data=%h, required 0/00000000", output_valid, data_out); end
    checks++;
    if (input_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready: input_ready=%b, required 1", input_ready); end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send_byte(8'h50 + 8'(i));
    checks++;
    if (output_valid !== 1'b1)
      begin errors++; $display("FAIL reset_pre_held: valid=%b, required 1", output_valid); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (output_valid !== 1'b0 || data_out !== 32'h0)
      begin errors++; $display("FAIL reset_async: valid=%b data=%h, required 0/00000000", output_valid, data_out); end
    tick();
    reset_n = 1'b1;
    clear_q();
    output_ready = 1'b1;
    tick();
    checks++;
    if (output_valid !== 1'b0)
      begin errors++; $display("FAIL reset_release: valid=%b, required 0", output_valid); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (3) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h44332211)
      begin errors++; $display("FAIL reset_word: count=%0d first=%h, required 1 word 44332211", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0); end
  endtask

  task automatic test_stream();
    int drops = 0;
    clear_q();
    output_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      input_valid = 1'b1;
      data_in = 8'(i + 1);
      #1;
      if (input_ready !== 1'b1) drops++;
      tick();
      if (i == 3) begin
        checks++;
        if (output_valid !== 1'b1 || data_out !== 32'h04030201)
          begin errors++; $display("FAIL stream_latency: valid=%b data=%h, required 1/04030201", output_valid, data_out); end
      end
    end
    input_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (drops != 0)
      begin errors++; $display("FAIL stream_ready: drops=%0d, required 0", drops); end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 32'h04030201 || got_q[1] !== 32'h08070605)
      begin errors++; $display("FAIL stream_words: count=%0d, required 2 words 04030201 08070605", got_q.size()); end
    checks++;
    if (got_t.size() != 2 || got_t[1] - got_t[0] != 4)
      begin errors++; $display("FAIL stream_spacing: count=%0d gap=%0d, required 4", got_t.size(), (got_t.size() == 2) ? got_t[1] - got_t[0] : -1); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  b[8];
    logic [31:0] w0, w1;
    int idx = 0;
    logic fired;
    clear_q();
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    w0 = {b[3], b[2], b[1], b[0]};
    w1 = {b[7], b[6], b[5], b[4]};
    output_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      input_valid = 1'b1;
      data_in = b[idx];
      #1;
      fired = input_ready;
      tick();
      if (fired) idx++;
    end
    checks++;
    if (idx != 7 || input_ready !== 1'b0)
      begin errors++; $display("FAIL bp_stall: accepted=%0d ready=%b, required 7/0", idx, input_ready); end
    checks++;
    if (output_valid !== 1'b1 || data_out !== w0)
      begin errors++; $display("FAIL bp_hold: valid=%b data=%h, required 1/%h", output_valid, data_out, w0); end
    output_ready = 1'b1;
    #1;
    checks++;
    if (input_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release_ready: input_ready=%b, required 1", input_ready); end
    tick();
    input_valid = 1'b0;
    checks++;
    if (output_valid !== 1'b1 || data_out !== w1)
      begin errors++; $display("FAIL bp_second: valid=%b data=%h, required 1/%h", output_valid, data_out, w1); end
    tick();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== w0 || got_q[1] !== w1 || output_valid !== 1'b0)
      begin errors++; $display("FAIL bp_words: count=%0d valid=%b, required 2 words %h %h then valid 0", got_q.size(), output_valid, w0, w1); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] old;
    clear_q();
    output_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    input_valid = 1'b1;
    data_in = 8'($urandom);
    output_ready = 1'b1;
    #1;
    checks++;
    if (input_ready !== 1'b1)
      begin errors++; $display("FAIL sim_ready: input_ready=%b, required 1", input_ready); end
    old = data_out;
    tick();
    input_valid = 1'b0;
    output_ready = 1'b0;
    checks++;
    if (output_valid !== 1'b1 || exp_q.size() != 2 || data_out !== exp_q[1])
      begin errors++; $display("FAIL sim_no_bubble: valid=%b data=%h old=%h, required 1 and new model word", output_valid, data_out, old); end
    tick();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 2 || got_q[0] !== exp_q[0])
      begin errors++; $display("FAIL sim_single: count=%0d, required 1 matching first model word", got_q.size()); end
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    tick();
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 2 || got_q[1] !== exp_q[1])
      begin errors++; $display("FAIL sim_words: count=%0d, required 2 matching model", got_q.size()); end
  endtask

  task automatic test_random();
    int sent = 0;
    int n = 0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic fire;
    clear_q();
    output_ready = 1'b0;
    input_valid = 1'b0;
    while (sent < 100 && n < 3000) begin
      if (n % 5 == 0) output_ready = ~output_ready;
      if (!input_valid) begin
        input_valid = 1'($urandom_range(0, 1));
        data_in = 8'($urandom);
      end
      #1;
      if (prev_hold) begin
        checks++;
        if (output_valid !== 1'b1 || data_out !== prev_data)
          begin errors++; $display("FAIL rand_stable: valid=%b data=%h, required 1/%h", output_valid, data_out, prev_data); end
      end
      prev_hold = output_valid && !output_ready;
      prev_data = data_out;
      fire = input_valid && input_ready;
      tick();
      if (fire) begin
        sent++;
        input_valid = 1'b0;
      end
      n++;
    end
    input_valid = 1'b0;
    output_ready = 1'b1;
    repeat (8) tick();
    checks++;
    if (n >= 3000)
      begin errors++; $display("FAIL rand_timeout: sent=%0d, required 100", sent); end
    checks++;
    if (got_q.size() != 25 || exp_q.size() != 25)
      begin errors++; $display("FAIL rand_count: got=%0d model=%0d, required 25", got_q.size(), exp_q.size()); end
    for (int i = 0; i < 25 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i])
        begin errors++; $display("FAIL rand_word%0d: got=%h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
  task automatic test_flush();
    clear_q();
    output_ready = 1'b1;
    send_byte(8'hAA);
    input_last = 1'b1;
    send_byte(8'hBB);
    input_last = 1'b0;
    checks++;
    if (output_valid !== 1'b1 || data_out !== 32'h0000BBAA || output_last !== 1'b1)
      begin errors++; $display("FAIL flush_short: valid=%b data=%h last=%b, required 1/0000BBAA/1", output_valid, data_out, output_last); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    checks++;
    if (output_valid !== 1'b1 || data_out !== 32'h04030201 || output_last !== 1'b0)
      begin errors++; $display("FAIL flush_full: valid=%b data=%h last=%b, required 1/04030201/0", output_valid, data_out, output_last); end
    tick();
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    input_valid = 1'b0;
    output_ready = 1'b0;
    data_in = 8'h00;
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    input_last = 1'b0;
`endif
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_random();
`ifdef BUS_WIDTH_INCREASE_FLUSH_EN
    test_flush();
`endif
    checks++;
    if (timeouts != 0)
      begin errors++; $display("FAIL send_timeout: timeouts=%0d, required 0", timeouts); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
